// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core memory stage and a word-addressed data RAM.
// Loads are extended from the RAM's right-justified data; sub-word stores are done as
// read-modify-write of the containing word so neighbouring bytes are preserved.
`timescale 1ns / 1ps

module lsu_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [2:0]            mem_rwtyp,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   output logic                  mem_rden,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StRdIssue,
      StRdWait,
      StWrIssue,
      StResp
   } state_e;

   state_e state_q, state_d;

   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  accept;
   logic                  req_legal;
   state_e                accept_state;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] merged;

   assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   // Legality of the presented request and the state it starts in once accepted.
   always_comb begin
      req_legal = 1'b0;
      case (req_funct3)
         F3Byte:  req_legal = 1'b1;
         F3Half:  req_legal = ~req_addr[0];
         F3Word:  req_legal = (req_addr[1:0] == 2'b00);
         F3ByteU: req_legal = ~req_we;
         F3HalfU: req_legal = ~req_we & ~req_addr[0];
         default: req_legal = 1'b0;
      endcase

      if (!req_legal) begin
         accept_state = StResp;
      end else if (req_we && (req_funct3 == F3Word)) begin
         accept_state = StWrIssue;
      end else begin
         // Loads and sub-word stores both start with a read.
         accept_state = StRdIssue;
      end
   end

   // Extend load data and build the merged RMW word from the current mem_q.
   always_comb begin
      case (funct3_q)
         F3Byte:  load_ext = {{(DATA_WIDTH-8){mem_q[7]}}, mem_q[7:0]};
         F3Half:  load_ext = {{(DATA_WIDTH-16){mem_q[15]}}, mem_q[15:0]};
         F3ByteU: load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_q[7:0]};
         F3HalfU: load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_q[15:0]};
         default: load_ext = mem_q;
      endcase

      merged = mem_q;
      if (funct3_q == F3Byte) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (funct3_q == F3Half) begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and all outputs, decoded from the current state and captured request.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_rwtyp = F3Word;
      mem_addr  = '0;
      mem_data  = '0;
      mem_wren  = 1'b0;
      mem_rden  = 1'b0;

      case (state_q)
         StIdle: begin
            req_ready = ~rst;
            if (req_valid) begin
               state_d = accept_state;
            end
         end
         StRdIssue: begin
            mem_rden = 1'b1;
            if (we_q) begin
               mem_addr = word_addr;
            end else begin
               mem_rwtyp = funct3_q;
               mem_addr  = addr_q;
            end
            state_d = StRdWait;
         end
         StRdWait: begin
            state_d = we_q ? StWrIssue : StResp;
         end
         StWrIssue: begin
            mem_wren = 1'b1;
            mem_addr = word_addr;
            mem_data = wdata_q;
            state_d  = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = rdata_q;
            // Accepting here gives the 3/2/4-cycle back-to-back spacing.
            req_ready = ~rst;
            state_d   = req_valid ? accept_state : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign accept = req_valid & req_ready;

   // Request capture on accept; load result or merged store word captured in RD_WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         funct3_q <= F3Word;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else if (accept) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
         rdata_q  <= '0;
         err_q    <= ~req_legal;
      end else if (state_q == StRdWait) begin
         if (we_q) begin
            wdata_q <= merged;
         end else begin
            rdata_q <= load_ext;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: behavioural word RAM, a vector table of single
// transactions, and hand sequences for reset, mid-RMW reset and back-to-back requests.
`timescale 1ns / 1ps

module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [2:0]  mem_rwtyp;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic        mem_rden;
   logic [31:0] mem_q;

   lsu_mem_ctrl #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_rwtyp (mem_rwtyp),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_wren  (mem_wren),
      .mem_rden  (mem_rden),
      .mem_q     (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word RAM: right-justified, zero-filled sub-word reads one cycle after rden.
   logic [31:0] ram [0:255];

   function automatic logic [31:0] ram_read(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] w);
      logic [31:0] r;
      case (t)
         3'b000, 3'b100: r = {24'h0, w[{a[1:0], 3'b000} +: 8]};
         3'b001, 3'b101: r = {16'h0, w[{a[1], 4'b0000} +: 16]};
         default:        r = w;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr[9:2]] <= mem_data;
      if (mem_rden) mem_q <= ram_read(mem_rwtyp, mem_addr, ram[mem_addr[9:2]]);
   end

   // Strobe and response monitor.
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          rsp_cnt = 0;
   int          overlap = 0;
   logic [31:0] last_wdata = '0;
   logic [31:0] last_waddr = '0;

   always @(negedge clk) begin
      if (mem_rden) rd_cnt <= rd_cnt + 1;
      if (mem_wren) begin
         wr_cnt     <= wr_cnt + 1;
         last_wdata <= mem_data;
         last_waddr <= mem_addr;
      end
      if (mem_rden && mem_wren) overlap <= overlap + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      logic [7:0]  lat;
      logic [7:0]  nrd;
      logic [7:0]  nwr;
      logic [31:0] wword;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic err,
                               input logic [31:0] rdata, input int lat, input int nrd,
                               input int nwr, input logic [31:0] wword);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
      v.lat = 8'(lat); v.nrd = 8'(nrd); v.nwr = 8'(nwr); v.wword = wword;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
   endtask

   // One isolated transaction; checks issue cycle, latency, response and strobe counts.
   task automatic run_vec(input vec_t v, input int idx);
      int  n;
      int  rd0;
      int  wr0;
      bit  got;
      @(negedge clk);
      drive(v);
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check($sformatf("v%0d ready timeout", idx), 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < 10 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1 && v.nrd != 0) begin
            check($sformatf("v%0d issue rden", idx), 32'(mem_rden), 32'd1);
            check($sformatf("v%0d issue rwtyp", idx), 32'(mem_rwtyp),
                  v.we ? 32'd2 : 32'(v.f3));
            check($sformatf("v%0d issue addr", idx), mem_addr,
                  v.we ? {v.addr[31:2], 2'b00} : v.addr);
         end else if (n == 1 && v.nwr != 0) begin
            check($sformatf("v%0d issue wren", idx), 32'(mem_wren), 32'd1);
         end
         if (rsp_valid) got = 1'b1;
      end
      check($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
      check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.err));
      check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rdata);
      check($sformatf("v%0d rden count", idx), 32'(rd_cnt - rd0), 32'(v.nrd));
      check($sformatf("v%0d wren count", idx), 32'(wr_cnt - wr0), 32'(v.nwr));
      if (v.nwr != 0) begin
         check($sformatf("v%0d write data", idx), last_wdata, v.wword);
         check($sformatf("v%0d write addr", idx), last_waddr, {v.addr[31:2], 2'b00});
      end
   endtask

   vec_t        vecs [21];
   vec_t        b2b [3];
   int          rsp0;
   int          wr0;
   int          cyc;
   int          ia;
   int          rn;
   int          acc_c [3];
   logic [31:0] rsp_d [3];
   bit          acc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //         we   f3     addr       wdata         err rdata          lat rd wr wword
      vecs[0]  = mk(1, 3'b010, 32'h100, 32'h0123_8045, 0, 32'h0,          2, 0, 1, 32'h0123_8045);
      vecs[1]  = mk(1, 3'b010, 32'h104, 32'h8001_7FFF, 0, 32'h0,          2, 0, 1, 32'h8001_7FFF);
      vecs[2]  = mk(1, 3'b010, 32'h200, 32'h1122_3344, 0, 32'h0,          2, 0, 1, 32'h1122_3344);
      vecs[3]  = mk(1, 3'b010, 32'h300, 32'hDEAD_0000, 0, 32'h0,          2, 0, 1, 32'hDEAD_0000);
      vecs[4]  = mk(0, 3'b000, 32'h101, 32'h0,         0, 32'hFFFF_FF80, 3, 1, 0, 32'h0);
      vecs[5]  = mk(0, 3'b100, 32'h101, 32'h0,         0, 32'h0000_0080, 3, 1, 0, 32'h0);
      vecs[6]  = mk(0, 3'b001, 32'h106, 32'h0,         0, 32'hFFFF_8001, 3, 1, 0, 32'h0);
      vecs[7]  = mk(0, 3'b101, 32'h106, 32'h0,         0, 32'h0000_8001, 3, 1, 0, 32'h0);
      vecs[8]  = mk(0, 3'b010, 32'h104, 32'h0,         0, 32'h8001_7FFF, 3, 1, 0, 32'h0);
      vecs[9]  = mk(1, 3'b000, 32'h202, 32'h0000_00AB, 0, 32'h0,          4, 1, 1, 32'h11AB_3344);
      vecs[10] = mk(0, 3'b010, 32'h200, 32'h0,         0, 32'h11AB_3344, 3, 1, 0, 32'h0);
      vecs[11] = mk(0, 3'b010, 32'h102, 32'h0,         1, 32'h0,          1, 0, 0, 32'h0);
      vecs[12] = mk(1, 3'b001, 32'h201, 32'h0000_5555, 1, 32'h0,          1, 0, 0, 32'h0);
      vecs[13] = mk(0, 3'b011, 32'h100, 32'h0,         1, 32'h0,          1, 0, 0, 32'h0);
      vecs[14] = mk(1, 3'b100, 32'h200, 32'h0000_0077, 1, 32'h0,          1, 0, 0, 32'h0);
      vecs[15] = mk(1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 32'h0,          2, 0, 1, 32'hCAFE_F00D);
      vecs[16] = mk(1, 3'b001, 32'h206, 32'hAAAA_1234, 0, 32'h0,          4, 1, 1, 32'h1234_F00D);
      vecs[17] = mk(0, 3'b000, 32'h207, 32'h0,         0, 32'h0000_0012, 3, 1, 0, 32'h0);
      vecs[18] = mk(0, 3'b101, 32'h204, 32'h0,         0, 32'h0000_F00D, 3, 1, 0, 32'h0);
      vecs[19] = mk(0, 3'b100, 32'h100, 32'h0,         0, 32'h0000_0045, 3, 1, 0, 32'h0);
      vecs[20] = mk(0, 3'b000, 32'h205, 32'h0,         0, 32'hFFFF_FFF0, 3, 1, 0, 32'h0);

      b2b[0] = mk(0, 3'b010, 32'h104, 32'h0,         0, 32'h8001_7FFF, 3, 1, 0, 32'h0);
      b2b[1] = mk(1, 3'b010, 32'h208, 32'h55AA_55AA, 0, 32'h0,          2, 0, 1, 32'h55AA_55AA);
      b2b[2] = mk(0, 3'b000, 32'h100, 32'h0,         0, 32'h0000_0045, 3, 1, 0, 32'h0);

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(posedge clk);

      // Reset state.
      @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset strobes", {30'd0, mem_rden, mem_wren}, 32'd0);
      check("reset mem_rwtyp", 32'(mem_rwtyp), 32'd2);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_data", mem_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

      // Reset in RD_WAIT of a halfword RMW store: write dropped, no response.
      @(negedge clk);
      rsp0 = rsp_cnt;
      wr0  = wr_cnt;
      drive(mk(1, 3'b001, 32'h300, 32'h0000_BEEF, 0, 0, 4, 1, 1, 32'hDEAD_BEEF));
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw-reset rd issue", 32'(mem_rden), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rmw-reset ready during rst", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rmw-reset ready after rst", 32'(req_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("rmw-reset no write", 32'(wr_cnt - wr0), 32'd0);
      check("rmw-reset no rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("rmw-reset ram", ram[8'hC0], 32'hDEAD_0000);

      // Back-to-back lw, sw, lb with req_valid held.
      rsp0 = rsp_cnt;
      drive(b2b[0]);
      req_valid = 1'b1;
      cyc = 0;
      ia  = 0;
      rn  = 0;
      while (cyc < 40 && rn < 3) begin
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            if (rn < 3) rsp_d[rn] = rsp_rdata;
            rn++;
         end
         if (acc) begin
            if (ia < 3) acc_c[ia] = cyc;
            ia++;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            if (ia < 3) drive(b2b[ia]);
            else req_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      check("b2b accepts", 32'(ia), 32'd3);
      check("b2b responses", 32'(rn), 32'd3);
      if (ia == 3 && rn == 3) begin
         check("b2b lw->sw spacing", 32'(acc_c[1] - acc_c[0]), 32'd3);
         check("b2b sw->lb spacing", 32'(acc_c[2] - acc_c[1]), 32'd2);
         for (int i = 0; i < 3; i++)
            check($sformatf("b2b rsp%0d rdata", i), rsp_d[i], b2b[i].rdata);
      end
      repeat (4) @(negedge clk);
      check("b2b total rsp", 32'(rsp_cnt - rsp0), 32'd3);
      check("b2b ram", ram[8'h82], 32'h55AA_55AA);

      // Final memory image and strobe exclusivity.
      check("ram 0x100", ram[8'h40], 32'h0123_8045);
      check("ram 0x200", ram[8'h80], 32'h11AB_3344);
      check("ram 0x204", ram[8'h81], 32'h1234_F00D);
      check("strobe overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
